// File: rtl/shift_reg_arbiter_ctrl.sv
// shift_reg_arbiter_ctrl
// Two requesters (A, B) share a single parallel-load shift engine. A
// round-robin arbiter grants one WIDTH-bit word at a time. The granted word
// is shifted out MSB-first, one bit per cycle. A one-cycle done pulse then
// tells the owning requester that its word has gone out.

module shift_reg_arbiter_ctrl #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a_valid,
    input  logic [WIDTH-1:0] req_a_data,
    output logic             req_a_ready,
    input  logic             req_b_valid,
    input  logic [WIDTH-1:0] req_b_data,
    output logic             req_b_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             owner,
    output logic             busy,
    output logic             done_a,
    output logic             done_b
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   shreg_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               owner_r;
    logic               last_served_r;
    logic               grant_a_s;
    logic               grant_b_s;
    logic               last_bit_s;

    assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

    // Round-robin arbitration, live only in IDLE and masked while reset is held
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if ((state_r == ST_IDLE) && !reset) begin
            if (req_a_valid && req_b_valid) begin
                // On a tie, the requester that was not served last wins
                if (last_served_r) begin
                    grant_a_s = 1'b1;
                end else begin
                    grant_b_s = 1'b1;
                end
            end else if (req_a_valid) begin
                grant_a_s = 1'b1;
            end else if (req_b_valid) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Next-state logic: IDLE -> SHIFT on grant, SHIFT -> DONE after WIDTH bits, DONE -> IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_a_s || grant_b_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: capture the winner's word on grant, then shift it left with zero fill
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r       <= {WIDTH{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            owner_r       <= 1'b0;
            last_served_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_a_s) begin
                        shreg_r       <= req_a_data;
                        cnt_r         <= {CNT_W{1'b0}};
                        owner_r       <= 1'b0;
                        last_served_r <= 1'b0;
                    end else if (grant_b_s) begin
                        shreg_r       <= req_b_data;
                        cnt_r         <= {CNT_W{1'b0}};
                        owner_r       <= 1'b1;
                        last_served_r <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
                ST_DONE: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Outputs are decoded from registered state; ready follows valid combinationally
    always_comb begin
        req_a_ready  = grant_a_s;
        req_b_ready  = grant_b_s;
        owner        = owner_r;
        serial_valid = (state_r == ST_SHIFT);
        serial_out   = (state_r == ST_SHIFT) ? shreg_r[WIDTH-1] : 1'b0;
        busy         = (state_r == ST_SHIFT) || (state_r == ST_DONE);
        done_a       = (state_r == ST_DONE) && !owner_r;
        done_b       = (state_r == ST_DONE) && owner_r;
    end

endmodule

// File: tb/tb_shift_reg_arbiter_ctrl.sv
// Self-checking bench for shift_reg_arbiter_ctrl (WIDTH=4).
// A cycle-level reference model predicts the grants. On each grant the
// expected serial bits and the done owner are pushed to scoreboard queues.
// These queues are popped when the DUT presents bits or done pulses.

module tb_shift_reg_arbiter_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         req_a_valid;
    logic [W-1:0] req_a_data;
    logic         req_a_ready;
    logic         req_b_valid;
    logic [W-1:0] req_b_data;
    logic         req_b_ready;
    logic         serial_out;
    logic         serial_valid;
    logic         owner;
    logic         busy;
    logic         done_a;
    logic         done_b;

    int errors = 0;
    int checks = 0;

    // reference model state
    int   m_phase;   // 0 idle, 1..W shift bit index, W+1 done
    logic m_owner;
    logic m_last;

    // scoreboard
    logic bitq[$];
    logic doneq[$];
    logic done_hist[$];

    int   cyc = 0;
    int   done_cnt;
    int   last_done_cyc;
    int   last_hs_a_cyc;
    int   last_hs_b_cyc;
    logic [W-1:0] seen_bits;

    shift_reg_arbiter_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_a_valid  (req_a_valid),
        .req_a_data   (req_a_data),
        .req_a_ready  (req_a_ready),
        .req_b_valid  (req_b_valid),
        .req_b_data   (req_b_data),
        .req_b_ready  (req_b_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .owner        (owner),
        .busy         (busy),
        .done_a       (done_a),
        .done_b       (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase       = 0;
        m_owner       = 1'b0;
        m_last        = 1'b1;
        bitq.delete();
        doneq.delete();
        done_hist.delete();
        done_cnt      = 0;
        last_done_cyc = -1;
        last_hs_a_cyc = -1;
        last_hs_b_cyc = -1;
        seen_bits     = '0;
    endtask

    // One clock cycle: settle, compare against model/scoreboard, advance model, cross edge
    task automatic tick();
        logic ea, eb, b, exp_da, exp_db, dn;
        #1;
        ea = (m_phase == 0) && req_a_valid && (!req_b_valid || m_last);
        eb = (m_phase == 0) && req_b_valid && (!req_a_valid || !m_last);
        checks++;
        if (req_a_ready !== ea) begin errors++; $display("FAIL ready_a cyc=%0d got=%b exp=%b", cyc, req_a_ready, ea); end
        checks++;
        if (req_b_ready !== eb) begin errors++; $display("FAIL ready_b cyc=%0d got=%b exp=%b", cyc, req_b_ready, eb); end
        checks++;
        if (serial_valid !== (m_phase >= 1 && m_phase <= W)) begin
            errors++; $display("FAIL serial_valid cyc=%0d got=%b phase=%0d", cyc, serial_valid, m_phase);
        end
        checks++;
        if (busy !== (m_phase != 0)) begin errors++; $display("FAIL busy cyc=%0d got=%b phase=%0d", cyc, busy, m_phase); end
        checks++;
        if (owner !== m_owner) begin errors++; $display("FAIL owner cyc=%0d got=%b exp=%b", cyc, owner, m_owner); end
        if (serial_valid === 1'b1) begin
            checks++;
            if (bitq.size() == 0) begin
                errors++; $display("FAIL serial_extra cyc=%0d got bit %b with empty queue", cyc, serial_out);
            end else begin
                b = bitq.pop_front();
                if (serial_out !== b) begin errors++; $display("FAIL serial_bit cyc=%0d got=%b exp=%b", cyc, serial_out, b); end
            end
            seen_bits = {seen_bits[W-2:0], serial_out};
        end else begin
            checks++;
            if (serial_out !== 1'b0) begin errors++; $display("FAIL serial_idle cyc=%0d got=%b exp=0", cyc, serial_out); end
        end
        exp_da = (m_phase == W + 1) && !m_owner;
        exp_db = (m_phase == W + 1) && m_owner;
        checks++;
        if (done_a !== exp_da) begin errors++; $display("FAIL done_a cyc=%0d got=%b exp=%b", cyc, done_a, exp_da); end
        checks++;
        if (done_b !== exp_db) begin errors++; $display("FAIL done_b cyc=%0d got=%b exp=%b", cyc, done_b, exp_db); end
        if (done_a === 1'b1 || done_b === 1'b1) begin
            checks++;
            if (doneq.size() == 0) begin
                errors++; $display("FAIL done_extra cyc=%0d got done with empty queue", cyc);
            end else begin
                dn = doneq.pop_front();
                if (done_b !== dn) begin errors++; $display("FAIL done_owner cyc=%0d got=%b exp=%b", cyc, done_b, dn); end
            end
            done_hist.push_back(done_b);
            done_cnt++;
            last_done_cyc = cyc;
        end
        // advance model across the coming edge
        if (m_phase == 0) begin
            if (ea || eb) begin
                for (int i = W - 1; i >= 0; i--) bitq.push_back(ea ? req_a_data[i] : req_b_data[i]);
                doneq.push_back(eb);
                m_owner = eb;
                m_last  = eb;
                m_phase = 1;
                if (ea) last_hs_a_cyc = cyc; else last_hs_b_cyc = cyc;
            end
        end else if (m_phase == W + 1) begin
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain_check(input string name);
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
        repeat (W + 3) tick();
        checks++;
        if (bitq.size() != 0 || doneq.size() != 0) begin
            errors++; $display("FAIL %s_drain bits_left=%0d dones_left=%0d exp=0", name, bitq.size(), doneq.size());
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        req_a_valid = 1'b1;
        req_b_valid = 1'b1;
        req_a_data  = 4'hF;
        req_b_data  = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_a_ready, req_b_ready, serial_out, serial_valid, owner, busy, done_a, done_b} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=00000000",
                     {req_a_ready, req_b_ready, serial_out, serial_valid, owner, busy, done_a, done_b});
        end
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
        reset       = 1'b0;
        model_reset();
    endtask

    task automatic test_single_a();
        int c0;
        test_reset();
        req_a_data  = 4'b1011;
        req_a_valid = 1'b1;
        c0 = cyc;
        tick();
        req_a_valid = 1'b0;
        req_a_data  = 4'b0000;
        repeat (6) tick();
        checks++;
        if (last_hs_a_cyc != c0) begin errors++; $display("FAIL t1_handshake got=%0d exp=%0d", last_hs_a_cyc, c0); end
        checks++;
        if (seen_bits !== 4'b1011) begin errors++; $display("FAIL t1_stream got=%b exp=1011", seen_bits); end
        checks++;
        if (last_done_cyc != c0 + 5 || done_cnt != 1) begin
            errors++; $display("FAIL t1_done got_cyc=%0d cnt=%0d exp_cyc=%0d cnt=1", last_done_cyc, done_cnt, c0 + 5);
        end
        checks++;
        if (done_hist.size() != 1 || done_hist[0] !== 1'b0) begin errors++; $display("FAIL t1_done_b got=%0d entries exp=one done_a", done_hist.size()); end
        drain_check("t1");
    endtask

    task automatic test_tie_alternate();
        int prev;
        logic exp_o;
        test_reset();
        req_a_data  = 4'hF;
        req_b_data  = 4'h0;
        req_a_valid = 1'b1;
        req_b_valid = 1'b1;
        prev = -1;
        repeat (24) begin
            tick();
            if (last_done_cyc == cyc - 1 && prev >= 0) begin
                checks++;
                if (last_done_cyc - prev != W + 2) begin
                    errors++; $display("FAIL t2_spacing got=%0d exp=%0d", last_done_cyc - prev, W + 2);
                end
            end
            if (last_done_cyc == cyc - 1) prev = last_done_cyc;
        end
        checks++;
        if (done_hist.size() != 4) begin
            errors++; $display("FAIL t2_count got=%0d exp=4", done_hist.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_o = (i % 2 == 1);
                checks++;
                if (done_hist[i] !== exp_o) begin errors++; $display("FAIL t2_order idx=%0d got=%b exp=%b", i, done_hist[i], exp_o); end
            end
        end
        drain_check("t2");
    endtask

    task automatic test_b_only();
        int c0;
        test_reset();
        req_b_data  = 4'h9;
        req_b_valid = 1'b1;
        c0 = cyc;
        repeat (18) tick();
        checks++;
        if (done_cnt != 3 || last_done_cyc != c0 + 17) begin
            errors++; $display("FAIL t3_rate got_cnt=%0d last=%0d exp_cnt=3 last=%0d", done_cnt, last_done_cyc, c0 + 17);
        end
        checks++;
        if (seen_bits !== 4'b1001) begin errors++; $display("FAIL t3_stream got=%b exp=1001", seen_bits); end
        checks++;
        if (last_hs_b_cyc != c0 + 12) begin errors++; $display("FAIL t3_grant got=%0d exp=%0d", last_hs_b_cyc, c0 + 12); end
        drain_check("t3");
    endtask

    task automatic test_busy_hold();
        int cb;
        test_reset();
        req_b_data  = 4'h6;
        req_b_valid = 1'b1;
        cb = cyc;
        tick();
        req_b_valid = 1'b0;
        tick();
        req_a_data  = 4'hA;
        req_a_valid = 1'b1;
        repeat (10) begin
            tick();
            if (last_hs_a_cyc >= 0) req_a_valid = 1'b0;
        end
        checks++;
        if (last_hs_a_cyc != cb + W + 2) begin errors++; $display("FAIL t4_a_grant got=%0d exp=%0d", last_hs_a_cyc, cb + W + 2); end
        checks++;
        if (seen_bits !== 4'hA || done_cnt != 2) begin
            errors++; $display("FAIL t4_a_word got=%h dones=%0d exp=a dones=2", seen_bits, done_cnt);
        end
        drain_check("t4");
    endtask

    task automatic test_reset_midshift();
        int c1;
        test_reset();
        req_a_data  = 4'hD;
        req_a_valid = 1'b1;
        tick();
        req_a_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({req_a_ready, req_b_ready, serial_out, serial_valid, owner, busy, done_a, done_b} !== 8'b0) begin
            errors++;
            $display("FAIL t5_async_reset got=%b exp=00000000",
                     {req_a_ready, req_b_ready, serial_out, serial_valid, owner, busy, done_a, done_b});
        end
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        model_reset();
        req_a_data  = 4'h3;
        req_b_data  = 4'hC;
        req_a_valid = 1'b1;
        req_b_valid = 1'b1;
        c1 = cyc;
        tick();
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
        repeat (6) tick();
        checks++;
        if (last_hs_a_cyc != c1 || last_hs_b_cyc != -1) begin
            errors++; $display("FAIL t5_tie got_a=%0d got_b=%0d exp_a=%0d exp_b=-1", last_hs_a_cyc, last_hs_b_cyc, c1);
        end
        checks++;
        if (done_cnt != 1 || seen_bits !== 4'h3) begin
            errors++; $display("FAIL t5_after got_dones=%0d bits=%h exp=1 and 3", done_cnt, seen_bits);
        end
        drain_check("t5");
    endtask

    task automatic test_data_change();
        test_reset();
        req_a_data  = 4'b1000;
        req_a_valid = 1'b1;
        tick();
        req_a_valid = 1'b0;
        req_a_data  = 4'b0111;
        repeat (6) tick();
        checks++;
        if (seen_bits !== 4'b1000 || done_cnt != 1) begin
            errors++; $display("FAIL t6_stream got=%b dones=%0d exp=1000 dones=1", seen_bits, done_cnt);
        end
        drain_check("t6");
    endtask

    initial begin
        reset       = 1'b1;
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
        req_a_data  = '0;
        req_b_data  = '0;
        model_reset();
        test_single_a();
        test_tie_alternate();
        test_b_only();
        test_busy_hold();
        test_reset_midshift();
        test_data_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
